// File: rtl/sram_arbiter.sv
// Shares the 16-bit board SRAM between fetch and memory stages.
// Each 32-bit word moves as two halfword phases, high half first.
module sram_arbiter #(
    parameter int ADDR_W     = 18,
    parameter int ACC_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              if_mc_req,
    input  logic [ADDR_W-1:0] if_mc_addr,
    output logic              mc_if_ack,
    output logic [31:0]       mc_if_data,
    input  logic              mem_mc_req,
    input  logic              mem_mc_rw,
    input  logic [ADDR_W-1:0] mem_mc_addr,
    input  logic [31:0]       mem_mc_wdata,
    output logic              mc_mem_ack,
    output logic [31:0]       mc_mem_rdata,
    output logic [ADDR_W-1:0] mc_ram_addr,
    inout  wire  [15:0]       mc_ram_data,
    output logic              mc_ram_we_n,
    output logic              mc_ram_oe_n,
    output logic              mc_ram_ce_n,
    output logic              mc_ram_ub_n,
    output logic              mc_ram_lb_n
);

    localparam int CW = $clog2(ACC_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        HI,
        LO,
        DONE
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic              gnt_mem;
    logic              last_mem;
    logic              rw;
    logic [ADDR_W-2:0] word;
    logic [31:0]       wdata;
    logic [15:0]       hi_q;
    logic              drv_en;
    logic [15:0]       drv_data;
    logic              pick_mem;
    logic              phase_end;
    logic              in_phase;
    logic              unused_bits;

    assign pick_mem    = mem_mc_req && (!if_mc_req || !last_mem);
    assign phase_end   = (cnt == CW'(ACC_CYCLES - 1));
    assign in_phase    = (state == HI) || (state == LO);
    assign mc_ram_data = drv_en ? drv_data : 16'hzzzz;
    assign unused_bits = if_mc_addr[0] ^ mem_mc_addr[0];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            gnt_mem      <= 1'b0;
            last_mem     <= 1'b0;
            rw           <= 1'b0;
            word         <= '0;
            wdata        <= '0;
            hi_q         <= '0;
            mc_if_ack    <= 1'b0;
            mc_mem_ack   <= 1'b0;
            mc_if_data   <= '0;
            mc_mem_rdata <= '0;
            mc_ram_addr  <= '0;
            mc_ram_we_n  <= 1'b1;
            mc_ram_oe_n  <= 1'b1;
            mc_ram_ce_n  <= 1'b1;
            mc_ram_ub_n  <= 1'b1;
            mc_ram_lb_n  <= 1'b1;
            drv_en       <= 1'b0;
            drv_data     <= '0;
        end else begin
            mc_if_ack  <= 1'b0;
            mc_mem_ack <= 1'b0;

            // pins trail the state by one clock so they leave a flop
            if (in_phase) begin
                mc_ram_addr <= {word, state == LO};
                mc_ram_ce_n <= 1'b0;
                mc_ram_ub_n <= 1'b0;
                mc_ram_lb_n <= 1'b0;
                mc_ram_oe_n <= rw;
                mc_ram_we_n <= !(rw && cnt != '0);
                drv_en      <= rw;
                drv_data    <= (state == LO) ? wdata[15:0] : wdata[31:16];
            end else begin
                mc_ram_ce_n <= 1'b1;
                mc_ram_ub_n <= 1'b1;
                mc_ram_lb_n <= 1'b1;
                mc_ram_oe_n <= 1'b1;
                mc_ram_we_n <= 1'b1;
                drv_en      <= 1'b0;
            end

            unique case (state)
                IDLE: begin
                    if (if_mc_req || mem_mc_req) begin
                        gnt_mem  <= pick_mem;
                        last_mem <= pick_mem;
                        word     <= pick_mem ? mem_mc_addr[ADDR_W-1:1]
                                             : if_mc_addr[ADDR_W-1:1];
                        rw       <= pick_mem && mem_mc_rw;
                        wdata    <= mem_mc_wdata;
                        cnt      <= '0;
                        state    <= HI;
                    end
                end
                HI: begin
                    if (phase_end) begin
                        cnt   <= '0;
                        state <= LO;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LO: begin
                    // bus now carries the last high-phase cycle
                    if (cnt == '0) hi_q <= mc_ram_data;
                    if (phase_end) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    if (gnt_mem) begin
                        mc_mem_ack <= 1'b1;
                        if (!rw) mc_mem_rdata <= {hi_q, mc_ram_data};
                    end else begin
                        mc_if_ack  <= 1'b1;
                        mc_if_data <= {hi_q, mc_ram_data};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
